// File: rtl/mux_pkg.sv
// Shared types for the stream multiplexer family.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt,
  output logic                 gnt_valid
);

  localparam int SELW = $clog2(N);

  int unsigned idx;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt       = '0;
    gnt_valid = |req;
    idx       = 0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % N;
      if (req[SELW'(idx)]) gnt = SELW'(idx);
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with explicit-select or round-robin grant
// and a registered output stage sustaining one transfer per cycle.
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_chan,
  input  logic                 out_ready
);

  localparam int SELW = $clog2(N);

  mode_e            mode_w;
  logic [SELW-1:0]  rr_gnt;
  logic             rr_valid;
  logic [SELW-1:0]  gnt;
  logic             gnt_valid;
  logic             sel_ok;
  logic             load;
  logic [WIDTH-1:0] data_sel;

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;

  assign mode_w = mode_e'(mode);
  assign load   = !out_valid_q || out_ready;

  rr_arbiter #(.N(N)) u_rr (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt       (rr_gnt),
    .gnt_valid (rr_valid)
  );

  // Grant selection; an out-of-range sel yields no grant rather than an X index.
  always_comb begin
    sel_ok = 1'b0;
    if (32'(sel) < 32'(N)) sel_ok = in_valid[sel];
    if (mode_w == MODE_RR) begin
      gnt       = rr_gnt;
      gnt_valid = rr_valid;
    end else begin
      gnt       = sel;
      gnt_valid = sel_ok;
    end
  end

  // Ready fan-out and data pick, driven from the grant index only.
  always_comb begin
    in_ready = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(gnt) == i) begin
        in_ready[i] = rst_n && load && gnt_valid;
        data_sel    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = data_sel;
        out_chan_d = gnt;
        if (mode_w == MODE_RR)
          ptr_d = (32'(gnt) == 32'(N - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  // State registers; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
